// File: rtl/ppu_pipe.sv
// Accelerator output post-processing: per-lane scale*acc+bias, optional ReLU,
// round half away from zero, symmetric saturation, elastic 2-stage valid/ready pipe.
module ppu_pipe #(
  parameter int LANES  = 16,
  parameter int ACC_W  = 24,
  parameter int COEF_W = 16,
  parameter int FRAC   = 10,
  parameter int OUT_W  = 18,
  parameter int ROWS   = 16,
  parameter int TILES  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_relu_en,
  input  logic                       i_coef_we,
  input  logic                       i_coef_sel,
  input  logic [$clog2(ROWS)-1:0]    i_coef_addr,
  input  logic [LANES*COEF_W-1:0]    i_coef_data,
  input  logic                       i_acc_valid,
  output logic                       o_acc_ready,
  input  logic [LANES*ACC_W-1:0]     i_acc_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [LANES*OUT_W-1:0]     o_data,
  output logic [$clog2(ROWS)-1:0]    o_row,
  output logic [$clog2(TILES)-1:0]   o_tile,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int RW     = $clog2(ROWS);
  localparam int TW     = $clog2(TILES);
  localparam int PROD_W = ACC_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int Q_W    = SUM_W - FRAC;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [Q_W-1:0] SAT_MAX = {{(Q_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  logic [1:0]              state, state_nx;
  logic [RW-1:0]           row_cnt;
  logic [TW-1:0]           tile_cnt;
  logic                    relu_q;

  logic [LANES*COEF_W-1:0] scale_tab [ROWS];
  logic [LANES*COEF_W-1:0] bias_tab  [ROWS];
  logic [LANES*COEF_W-1:0] scale_row, bias_row;

  logic                    s1_full;
  logic [LANES*SUM_W-1:0]  s1_sum, s1_sum_nx;
  logic [RW-1:0]           s1_row;
  logic [TW-1:0]           s1_tile;

  logic                    s2_full;
  logic [LANES*OUT_W-1:0]  s2_data, s2_data_nx;
  logic [RW-1:0]           s2_row;
  logic [TW-1:0]           s2_tile;

  logic s1_adv, s2_adv, acc_fire, last_beat, tab_we;

  // Signed multiply-accumulate on sign-extended operands; the sum carries one
  // guard bit so adding the bias can never overflow.
  function automatic logic [SUM_W-1:0] mac(input logic [COEF_W-1:0] sc,
                                           input logic [ACC_W-1:0]  ac,
                                           input logic [COEF_W-1:0] bi);
    logic signed [PROD_W-1:0] sc_x, ac_x, pr;
    sc_x = {{(PROD_W-COEF_W){sc[COEF_W-1]}}, sc};
    ac_x = {{(PROD_W-ACC_W){ac[ACC_W-1]}}, ac};
    pr   = sc_x * ac_x;
    return {pr[PROD_W-1], pr} + {{(SUM_W-COEF_W){bi[COEF_W-1]}}, bi};
  endfunction

  // ReLU, then round on the magnitude so ties move away from zero, then clamp
  // symmetrically so the most negative code never appears.
  function automatic logic [OUT_W-1:0] post(input logic [SUM_W-1:0] s, input logic relu);
    logic             neg;
    logic [SUM_W-1:0] mag;
    logic [Q_W-1:0]   q;
    logic [OUT_W-1:0] qs;
    neg = s[SUM_W-1] & ~relu;
    if (relu & s[SUM_W-1]) mag = '0;
    else                   mag = neg ? (~s + SUM_W'(1)) : s;
    q  = mag[SUM_W-1:FRAC] + Q_W'(mag[FRAC-1]);
    qs = (q > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : q[OUT_W-1:0];
    return neg ? (~qs + OUT_W'(1)) : qs;
  endfunction

  assign s2_adv      = s2_full & i_ready;
  assign s1_adv      = s1_full & (~s2_full | i_ready);
  assign o_acc_ready = (state == S_RUN) & (~s1_full | s1_adv);
  assign acc_fire    = i_acc_valid & o_acc_ready;
  assign last_beat   = (row_cnt == RW'(ROWS-1)) & (tile_cnt == TW'(TILES-1));
  assign tab_we      = (state == S_IDLE) & i_coef_we;
  // In DRAIN nothing new enters, so the final beat is the one leaving stage 2 with stage 1 empty.
  assign o_done      = (state == S_DRAIN) & s2_adv & ~s1_full;
  assign o_busy      = (state != S_IDLE);

  assign o_valid = s2_full;
  assign o_data  = s2_data;
  assign o_row   = s2_row;
  assign o_tile  = s2_tile;

  // NOTE: coefficient tables are plain storage with no reset so they map onto
  // RAM; the host must load them before the first pass.
  // NOTE: every sequential assignment uses <= so all registers update from
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (tab_we) begin
      if (i_coef_sel) bias_tab[i_coef_addr]  <= i_coef_data;
      else            scale_tab[i_coef_addr] <= i_coef_data;
    end
  end

  assign scale_row = scale_tab[row_cnt];
  assign bias_row  = bias_tab[row_cnt];

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      S_IDLE:  if (i_start)              state_nx = S_RUN;
      S_RUN:   if (acc_fire & last_beat) state_nx = S_DRAIN;
      S_DRAIN: if (o_done)               state_nx = S_IDLE;
      default:                           state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      tile_cnt <= '0;
      relu_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && i_start) relu_q <= i_relu_en;
      if (acc_fire) begin
        if (row_cnt == RW'(ROWS-1)) begin
          row_cnt  <= '0;
          tile_cnt <= (tile_cnt == TW'(TILES-1)) ? '0 : tile_cnt + TW'(1);
        end else begin
          row_cnt  <= row_cnt + RW'(1);
        end
      end
    end
  end

  always_comb begin
    s1_sum_nx = '0;
    for (int l = 0; l < LANES; l++)
      s1_sum_nx[l*SUM_W +: SUM_W] = mac(scale_row[l*COEF_W +: COEF_W],
                                        i_acc_data[l*ACC_W +: ACC_W],
                                        bias_row[l*COEF_W +: COEF_W]);
  end

  always_comb begin
    s2_data_nx = '0;
    for (int l = 0; l < LANES; l++)
      s2_data_nx[l*OUT_W +: OUT_W] = post(s1_sum[l*SUM_W +: SUM_W], relu_q);
  end

  // Each stage loads when its upstream advances and empties only when it
  // hands off without a replacement, so stalled data holds in place.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_full <= 1'b0;
      s1_sum  <= '0;
      s1_row  <= '0;
      s1_tile <= '0;
      s2_full <= 1'b0;
      s2_data <= '0;
      s2_row  <= '0;
      s2_tile <= '0;
    end else begin
      if (acc_fire) begin
        s1_full <= 1'b1;
        s1_sum  <= s1_sum_nx;
        s1_row  <= row_cnt;
        s1_tile <= tile_cnt;
      end else if (s1_adv) begin
        s1_full <= 1'b0;
      end
      if (s1_adv) begin
        s2_full <= 1'b1;
        s2_data <= s2_data_nx;
        s2_row  <= s1_row;
        s2_tile <= s1_tile;
      end else if (s2_adv) begin
        s2_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_pipe.sv
// Self-checking bench for ppu_pipe: directed vector table, randomized passes
// against an arithmetic reference model, and a mid-pass reset.
module tb_ppu_pipe;

  localparam int LANES = 16, ACC_W = 24, COEF_W = 16, FRAC = 10, OUT_W = 18;
  localparam int ROWS = 16, TILES = 4, RW = 4, TW = 2;
  localparam int PASS_BEATS = ROWS * TILES;
  localparam longint OUT_MAX = (longint'(1) <<< (OUT_W-1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, relu_en = 1'b0, coef_we = 1'b0, coef_sel = 1'b0;
  logic [RW-1:0] coef_addr = '0;
  logic [LANES*COEF_W-1:0] coef_data = '0;
  logic acc_valid = 1'b0, acc_ready;
  logic [LANES*ACC_W-1:0] acc_data = '0;
  logic o_valid, ready = 1'b0;
  logic [LANES*OUT_W-1:0] data;
  logic [RW-1:0] row;
  logic [TW-1:0] tile;
  logic busy, done;

  ppu_pipe #(.LANES(LANES), .ACC_W(ACC_W), .COEF_W(COEF_W), .FRAC(FRAC),
             .OUT_W(OUT_W), .ROWS(ROWS), .TILES(TILES)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_relu_en(relu_en),
    .i_coef_we(coef_we), .i_coef_sel(coef_sel), .i_coef_addr(coef_addr),
    .i_coef_data(coef_data), .i_acc_valid(acc_valid), .o_acc_ready(acc_ready),
    .i_acc_data(acc_data), .o_valid(o_valid), .i_ready(ready), .o_data(data),
    .o_row(row), .o_tile(tile), .o_busy(busy), .o_done(done));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [LANES*OUT_W-1:0] act,
                       input logic [LANES*OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: real-valued arithmetic on integers, no bit-level tricks.
  function automatic logic [OUT_W-1:0] ref_lane(input int sc, input int acc,
                                                input int bi, input bit relu);
    longint s, mag, q;
    s = longint'(sc) * longint'(acc) + longint'(bi);
    if (relu && s < 0) s = 0;
    mag = (s < 0) ? -s : s;
    q = (mag + (longint'(1) <<< (FRAC-1))) / (longint'(1) <<< FRAC);
    if (q > OUT_MAX) q = OUT_MAX;
    return OUT_W'((s < 0) ? -q : q);
  endfunction

  int m_scale [ROWS][LANES];
  int m_bias  [ROWS][LANES];

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    logic [RW-1:0]          row;
    logic [TW-1:0]          tile;
  } beat_t;

  beat_t exp_q[$];
  bit    mon_en = 1'b0, mon_relu = 1'b0;
  int    in_cnt = 0, out_cnt = 0, done_cnt = 0;
  bit    hold_pend = 1'b0;
  logic [LANES*OUT_W+RW+TW-1:0] hold_val;

  // Scoreboard: capture expected beats at input handshake, compare at output handshake.
  always @(negedge clk) begin
    beat_t eb, gb;
    int a, r;
    #2;
    if (mon_en) begin
      if (hold_pend) begin
        check("hold_valid", LANES*OUT_W'(o_valid), LANES*OUT_W'(1));
        check("hold_data", data, hold_val[LANES*OUT_W+RW+TW-1:RW+TW]);
        check("hold_rowtile", LANES*OUT_W'({row, tile}), LANES*OUT_W'(hold_val[RW+TW-1:0]));
      end
      hold_pend = o_valid && !ready;
      hold_val  = {data, row, tile};
      if (acc_valid && acc_ready) begin
        r = in_cnt % ROWS;
        for (int l = 0; l < LANES; l++) begin
          a = int'($signed(acc_data[l*ACC_W +: ACC_W]));
          eb.data[l*OUT_W +: OUT_W] = ref_lane(m_scale[r][l], a, m_bias[r][l], mon_relu);
        end
        eb.row  = RW'(r);
        eb.tile = TW'((in_cnt / ROWS) % TILES);
        exp_q.push_back(eb);
        in_cnt++;
      end
      if (o_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", LANES*OUT_W'(1), '0);
        end else begin
          gb = exp_q.pop_front();
          check("out_data", data, gb.data);
          check("out_row", LANES*OUT_W'(row), LANES*OUT_W'(gb.row));
          check("out_tile", LANES*OUT_W'(tile), LANES*OUT_W'(gb.tile));
        end
        out_cnt++;
        if (done) begin
          done_cnt++;
          check("done_on_last", LANES*OUT_W'(out_cnt), LANES*OUT_W'(PASS_BEATS));
        end
      end else if (done) begin
        done_cnt++;
        check("done_without_handshake", LANES*OUT_W'(1), '0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; acc_valid = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_row(input bit sel, input int addr, input bit with_start, input bit relu);
    @(negedge clk);
    coef_we = 1'b1; coef_sel = sel; coef_addr = RW'(addr);
    for (int l = 0; l < LANES; l++)
      coef_data[l*COEF_W +: COEF_W] = COEF_W'(sel ? m_bias[addr][l] : m_scale[addr][l]);
    start = with_start; relu_en = relu;
    @(negedge clk);
    coef_we = 1'b0; start = 1'b0;
  endtask

  task automatic load_random_tables();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++) begin
        m_scale[r][l] = int'($urandom_range(0, 4095)) - 2048;
        m_bias[r][l]  = int'($urandom_range(0, 65535)) - 32768;
      end
    for (int r = 0; r < ROWS; r++) begin
      write_row(1'b0, r, 1'b0, 1'b0);
      write_row(1'b1, r, 1'b0, 1'b0);
    end
  endtask

  // mode 0: valid always high, ready toggles each cycle; mode 1: random both,
  // plus stray start/table writes that must be ignored while busy.
  task automatic run_pass(input bit relu, input int mode, input int abort_at);
    int limit, cyc;
    limit = (abort_at > 0) ? abort_at : PASS_BEATS;
    @(negedge clk);
    exp_q.delete(); in_cnt = 0; out_cnt = 0; done_cnt = 0; hold_pend = 1'b0;
    mon_relu = relu; mon_en = 1'b1;
    start = 1'b1; relu_en = relu;
    cyc = 0;
    while (cyc < 4000 && ((abort_at > 0) ? (in_cnt < abort_at) : (done_cnt == 0))) begin
      @(negedge clk);
      start = 1'b0; coef_we = 1'b0;
      acc_valid = (in_cnt < limit) && ((mode == 0) || ($urandom_range(0, 3) != 0));
      for (int l = 0; l < LANES; l++)
        acc_data[l*ACC_W +: ACC_W] = ($urandom_range(0, 7) == 0) ? ACC_W'($urandom)
                                     : ACC_W'(int'($urandom_range(0, 65535)) - 32768);
      ready = (mode == 0) ? cyc[0] : ($urandom_range(0, 2) != 0);
      if (mode == 1 && in_cnt > 0 && in_cnt < PASS_BEATS - 4) begin
        coef_we   = ($urandom_range(0, 7) == 0);
        coef_sel  = $urandom_range(0, 1) != 0;
        coef_addr = RW'($urandom);
        coef_data = {8{$urandom}};
        start     = ($urandom_range(0, 7) == 0);
      end
      cyc++;
    end
    start = 1'b0; coef_we = 1'b0; acc_valid = 1'b0;
    if (abort_at == 0) begin
      ready = 1'b1;
      repeat (3) @(negedge clk);
      check("pass_done_count", LANES*OUT_W'(done_cnt), LANES*OUT_W'(1));
      check("pass_out_count", LANES*OUT_W'(out_cnt), LANES*OUT_W'(PASS_BEATS));
      check("pass_queue_empty", LANES*OUT_W'(exp_q.size()), '0);
      #1 check("pass_idle", LANES*OUT_W'(busy), '0);
      mon_en = 1'b0;
    end else begin
      check("abort_reached", LANES*OUT_W'(in_cnt >= abort_at), LANES*OUT_W'(1));
    end
  endtask

  typedef struct {
    string name;
    int    scale;
    int    bias;
    int    acc;
    bit    relu;
    int    exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    logic [OUT_W-1:0] e18;

    vecs[0] = '{"unity_pos",    1024,     0,        5, 1'b0,       5};
    vecs[1] = '{"unity_neg",    1024,     0,       -5, 1'b0,      -5};
    vecs[2] = '{"round_half",   1536,     0,        3, 1'b0,       5};
    vecs[3] = '{"round_half_n", 1536,     0,       -3, 1'b0,      -5};
    vecs[4] = '{"relu_clamp",   1024, -2048,        1, 1'b1,       0};
    vecs[5] = '{"relu_pass",    1024, -2048,        7, 1'b1,       5};
    vecs[6] = '{"sat_pos",     32767,     0,  8388607, 1'b0,  131071};
    vecs[7] = '{"sat_neg",     32767,     0, -8388607, 1'b0, -131071};
    vecs[8] = '{"no_relu_neg",  1024, -2048,        1, 1'b0,      -1};
    vecs[9] = '{"bias_half_n",  1024,  -512,        0, 1'b0,      -1};

    #1;
    check("rst_valid", LANES*OUT_W'(o_valid), '0);
    check("rst_busy", LANES*OUT_W'(busy), '0);
    check("rst_done", LANES*OUT_W'(done), '0);
    check("rst_acc_ready", LANES*OUT_W'(acc_ready), '0);
    check("rst_data", data, '0);
    check("rst_rowtile", LANES*OUT_W'({row, tile}), '0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      do_reset();
      for (int l = 0; l < LANES; l++) begin
        m_scale[0][l] = vecs[v].scale;
        m_bias[0][l]  = vecs[v].bias;
      end
      write_row(1'b0, 0, 1'b0, 1'b0);
      write_row(1'b1, 0, 1'b1, vecs[v].relu);
      acc_valid = 1'b1; ready = 1'b1;
      acc_data = {LANES{ACC_W'(vecs[v].acc)}};
      #1 check({vecs[v].name, "_acc_ready"}, LANES*OUT_W'(acc_ready), LANES*OUT_W'(1));
      @(negedge clk);
      acc_valid = 1'b0;
      lat = 1;
      while (lat < 8) begin
        #1;
        if (o_valid) break;
        @(negedge clk);
        lat++;
      end
      e18 = OUT_W'(vecs[v].exp);
      check({vecs[v].name, "_latency"}, LANES*OUT_W'(lat), LANES*OUT_W'(2));
      check({vecs[v].name, "_data"}, data, {LANES{e18}});
      check({vecs[v].name, "_rowtile"}, LANES*OUT_W'({row, tile}), '0);
    end

    do_reset();
    load_random_tables();
    run_pass(1'b0, 0, 0);
    load_random_tables();
    run_pass(1'b1, 1, 0);

    load_random_tables();
    run_pass(1'b0, 1, 20);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    check("midrst_valid", LANES*OUT_W'(o_valid), '0);
    check("midrst_data", data, '0);
    check("midrst_busy", LANES*OUT_W'(busy), '0);
    check("midrst_acc_ready", LANES*OUT_W'(acc_ready), '0);
    check("midrst_rowtile", LANES*OUT_W'({row, tile}), '0);
    @(negedge clk);
    rst = 1'b0;
    run_pass(1'($urandom_range(0, 1)), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
